// File: rtl/boot_pkg.sv
// ---------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding, stream field widths and small helper functions used by the
// loader datapath.
// ---------------------------------------------------------------------------
package boot_pkg;

    localparam int LEN_W  = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        S_LEN_HI = 3'd0,
        S_LEN_LO = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_RUN    = 3'd4,
        S_ERR    = 3'd5
    } boot_state_e;

    // Running checksum step: 8-bit add that wraps modulo 256.
    function automatic logic [BYTE_W-1:0] csum_add(
        input logic [BYTE_W-1:0] sum,
        input logic [BYTE_W-1:0] data
    );
        csum_add = sum + data;
    endfunction

    // The loader accepts bytes in every non-terminal state.
    function automatic logic state_accepts(input boot_state_e s);
        case (s)
            S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: state_accepts = 1'b1;
            S_RUN, S_ERR:                       state_accepts = 1'b0;
            default:                            state_accepts = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Receives a length-prefixed, checksummed program image over a valid/ready
// byte stream and writes it into byte-wide instruction memory. The processor
// is held in reset until the image is loaded and its checksum verified.
//
// Ports:
//   clk, rst       single clock, synchronous active-high reset
//   in_valid       source presents a byte on in_data
//   in_data[7:0]   stream byte (LEN_HI, LEN_LO, N payload bytes, CSUM)
//   in_ready       loader accepts a byte (function of state only)
//   mem_we         registered one-cycle byte write strobe
//   mem_addr       byte address of the write
//   mem_wdata      byte to write
//   cpu_run        releases the processor; sticky until rst
//   err            image rejected; sticky until rst
//   bytes_loaded   payload bytes written so far
// ---------------------------------------------------------------------------
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int MEM_DEPTH = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_run,
    output logic              err,
    output logic [15:0]       bytes_loaded
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MEM_DEPTH);

    boot_state_e        state_q, state_d;
    logic [BYTE_W-1:0]  len_hi_q, len_hi_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [BYTE_W-1:0]  sum_q, sum_d;
    logic               in_ready_q, in_ready_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [BYTE_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               cpu_run_q, cpu_run_d;
    logic               err_q, err_d;
    logic [LEN_W-1:0]   bytes_loaded_q, bytes_loaded_d;

    logic               accept_s;
    logic [LEN_W-1:0]   new_len_s;
    logic [LEN_W-1:0]   count_inc_s;

    assign accept_s    = in_valid && in_ready_q;
    assign new_len_s   = {len_hi_q, in_data};
    assign count_inc_s = count_q + 16'd1;

    // Next-state and datapath control for the load FSM.
    always_comb begin
        state_d        = state_q;
        len_hi_d       = len_hi_q;
        len_d          = len_q;
        count_d        = count_q;
        sum_d          = sum_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        cpu_run_d      = cpu_run_q;
        err_d          = err_q;
        bytes_loaded_d = bytes_loaded_q;

        case (state_q)
            S_LEN_HI: begin
                if (accept_s) begin
                    len_hi_d = in_data;
                    state_d  = S_LEN_LO;
                end else begin
                    state_d  = S_LEN_HI;
                end
            end

            S_LEN_LO: begin
                if (accept_s) begin
                    len_d = new_len_s;
                    // Compare at full 16-bit width so large lengths can never alias.
                    if ((new_len_s > MAX_LEN) || (new_len_s[1:0] != 2'b00)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (new_len_s == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_LEN_LO;
                end
            end

            S_DATA: begin
                if (accept_s) begin
                    mem_we_d       = 1'b1;
                    mem_addr_d     = count_q[ADDR_W-1:0];
                    mem_wdata_d    = in_data;
                    sum_d          = csum_add(sum_q, in_data);
                    count_d        = count_inc_s;
                    bytes_loaded_d = count_inc_s;
                    if (count_inc_s == len_q) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end

            S_CSUM: begin
                if (accept_s) begin
                    if (in_data == sum_q) begin
                        state_d   = S_RUN;
                        cpu_run_d = 1'b1;
                    end else begin
                        state_d   = S_ERR;
                        err_d     = 1'b1;
                    end
                end else begin
                    state_d = S_CSUM;
                end
            end

            S_RUN: begin
                state_d = S_RUN;
            end

            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                // An illegal encoding is treated as a rejected image so the
                // processor is never released from a corrupted state.
                state_d = S_ERR;
                err_d   = 1'b1;
            end
        endcase

        in_ready_d = state_accepts(state_d);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_LEN_HI;
            len_hi_q       <= 8'd0;
            len_q          <= 16'd0;
            count_q        <= 16'd0;
            sum_q          <= 8'd0;
            in_ready_q     <= 1'b1;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= 8'd0;
            cpu_run_q      <= 1'b0;
            err_q          <= 1'b0;
            bytes_loaded_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            len_hi_q       <= len_hi_d;
            len_q          <= len_d;
            count_q        <= count_d;
            sum_q          <= sum_d;
            in_ready_q     <= in_ready_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            cpu_run_q      <= cpu_run_d;
            err_q          <= err_d;
            bytes_loaded_q <= bytes_loaded_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_run      = cpu_run_q;
    assign err          = err_q;
    assign bytes_loaded = bytes_loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
// Directed self-checking bench for imem_boot_loader. A negedge monitor logs
// every memory write; scenario tasks drive byte streams and compare outputs
// and the write log against hand-computed values.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_run;
    logic        err;
    logic [15:0] bytes_loaded;

    int tests_run;
    int tests_failed;

    // Write log owned by the monitor.
    int         wr_cnt;
    logic [4:0] log_addr [0:127];
    logic [7:0] log_data [0:127];

    imem_boot_loader #(.MEM_DEPTH(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_run      (cpu_run),
        .err          (err),
        .bytes_loaded (bytes_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every cycle in which the write strobe is high.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_cnt < 128) begin
                log_addr[wr_cnt] = mem_addr;
                log_data[wr_cnt] = mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    // Present one byte after 'gap' idle cycles and wait for it to be accepted.
    // Returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            guard++;
            if (guard > 20) begin
                tests_run++;
                tests_failed++;
                $display("FAIL send_timeout: in_ready=%b byte=%h, required in_ready=1", in_ready, b);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_run, err, bytes_loaded} !==
            {1'b1, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: rdy=%b we=%b a=%h d=%h run=%b err=%b bl=%0d, required 1 0 00 00 0 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_run, err, bytes_loaded);
        end
    endtask

    // Eight-byte image; checksum byte is the mod-256 sum of the payload.
    task automatic test_good_image();
        logic [7:0] img [0:7];
        logic [7:0] csum;
        int base;
        img[0] = 8'h8C; img[1] = 8'h01; img[2] = 8'h00; img[3] = 8'h00;
        img[4] = 8'hAC; img[5] = 8'h01; img[6] = 8'h00; img[7] = 8'h04;
        csum = 8'h3E; // 0x8C + 0xAC + 0x01 + 0x01 + 0x04 = 0x13E
        apply_reset();
        base = wr_cnt;
        send_byte(8'h00, 0);
        send_byte(8'h08, 0);
        for (int i = 0; i < 8; i++) begin
            send_byte(img[i], 0);
            tests_run++;
            if (mem_we !== 1'b1 || mem_addr !== 5'(i) || mem_wdata !== img[i] ||
                bytes_loaded !== 16'(i + 1)) begin
                tests_failed++;
                $display("FAIL good_write%0d: we=%b a=%0d d=%h bl=%0d, required 1 %0d %h %0d",
                         i, mem_we, mem_addr, mem_wdata, bytes_loaded, i, img[i], i + 1);
            end
        end
        tests_run++;
        if (cpu_run !== 1'b0) begin
            tests_failed++;
            $display("FAIL good_run_early: cpu_run=%b, required 0", cpu_run);
        end
        send_byte(csum, 0);
        tests_run++;
        if (cpu_run !== 1'b1 || err !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL good_release: run=%b err=%b rdy=%b we=%b, required 1 0 0 0",
                     cpu_run, err, in_ready, mem_we);
        end
        // Bytes offered after release must be ignored.
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests_run++;
        if (wr_cnt - base !== 8 || bytes_loaded !== 16'd8 || cpu_run !== 1'b1) begin
            tests_failed++;
            $display("FAIL good_total: writes=%0d bl=%0d run=%b, required 8 8 1",
                     wr_cnt - base, bytes_loaded, cpu_run);
        end
    endtask

    task automatic test_bad_csum();
        logic [7:0] img [0:7];
        img[0] = 8'h8C; img[1] = 8'h01; img[2] = 8'h00; img[3] = 8'h00;
        img[4] = 8'hAC; img[5] = 8'h01; img[6] = 8'h00; img[7] = 8'h04;
        apply_reset();
        send_byte(8'h00, 1);
        send_byte(8'h08, 0);
        for (int i = 0; i < 8; i++) send_byte(img[i], i % 2);
        send_byte(8'h3F, 2);
        tests_run++;
        if (err !== 1'b1 || cpu_run !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bad_csum: err=%b run=%b rdy=%b, required 1 0 0", err, cpu_run, in_ready);
        end
    endtask

    task automatic test_len_error(input logic [7:0] lo, input string name);
        int base;
        apply_reset();
        base = wr_cnt;
        send_byte(8'h00, 0);
        send_byte(lo, 0);
        tests_run++;
        if (err !== 1'b1 || in_ready !== 1'b0 || cpu_run !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: err=%b rdy=%b run=%b, required 1 0 0", name, err, in_ready, cpu_run);
        end
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests_run++;
        if (wr_cnt - base !== 0) begin
            tests_failed++;
            $display("FAIL %s_writes: writes=%0d, required 0", name, wr_cnt - base);
        end
    endtask

    task automatic test_zero_len();
        int base;
        apply_reset();
        base = wr_cnt;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        tests_run++;
        if (cpu_run !== 1'b1 || err !== 1'b0 || wr_cnt - base !== 0) begin
            tests_failed++;
            $display("FAIL zero_len_ok: run=%b err=%b writes=%0d, required 1 0 0",
                     cpu_run, err, wr_cnt - base);
        end
        apply_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        tests_run++;
        if (err !== 1'b1 || cpu_run !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_len_bad: err=%b run=%b, required 1 0", err, cpu_run);
        end
    endtask

    // 32-byte image with gaps, reset mid-load, then a full back-to-back reload.
    task automatic test_reset_midload();
        logic [7:0] img [0:31];
        logic [7:0] csum;
        logic [7:0] mem_model [0:31];
        int base;
        int snap;
        csum = 8'h00;
        for (int i = 0; i < 32; i++) begin
            img[i] = 8'((i * 7) + 3);
            csum   = csum + img[i];
        end
        apply_reset();
        base = wr_cnt;
        send_byte(8'h00, 2);
        send_byte(8'h20, 1);
        for (int i = 0; i < 10; i++) send_byte(img[i], i % 3);
        tests_run++;
        if (bytes_loaded !== 16'd10 || mem_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL midload_count: bl=%0d we=%b, required 10 1", bytes_loaded, mem_we);
        end
        // Offer the 11th byte in the same cycle rst is asserted: it must be dropped.
        in_valid = 1'b1;
        in_data  = img[10];
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        tests_run++;
        if (mem_we !== 1'b0 || bytes_loaded !== 16'd0 || in_ready !== 1'b1 || mem_addr !== 5'd0) begin
            tests_failed++;
            $display("FAIL midload_reset: we=%b bl=%0d rdy=%b a=%0d, required 0 0 1 0",
                     mem_we, bytes_loaded, in_ready, mem_addr);
        end
        repeat (3) @(posedge clk);
        #1;
        snap = wr_cnt - base;
        tests_run++;
        if (snap !== 10) begin
            tests_failed++;
            $display("FAIL midload_writes: writes=%0d, required 10", snap);
        end
        base = wr_cnt;
        send_byte(8'h00, 0);
        send_byte(8'h20, 0);
        for (int i = 0; i < 32; i++) send_byte(img[i], 0);
        send_byte(csum, 0);
        tests_run++;
        if (cpu_run !== 1'b1 || err !== 1'b0 || wr_cnt - base !== 32 || bytes_loaded !== 16'd32) begin
            tests_failed++;
            $display("FAIL reload_done: run=%b err=%b writes=%0d bl=%0d, required 1 0 32 32",
                     cpu_run, err, wr_cnt - base, bytes_loaded);
        end
        for (int i = 0; i < 32; i++) mem_model[i] = 8'hXX;
        for (int i = 0; i < 32; i++) begin
            if (log_addr[base + i] !== 5'(i)) begin
                tests_run++;
                tests_failed++;
                $display("FAIL reload_order: write %0d addr=%0d, required %0d", i, log_addr[base + i], i);
            end
            mem_model[log_addr[base + i]] = log_data[base + i];
        end
        for (int i = 0; i < 32; i++) begin
            tests_run++;
            if (mem_model[i] !== img[i]) begin
                tests_failed++;
                $display("FAIL reload_mem%0d: data=%h, required %h", i, mem_model[i], img[i]);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        wr_cnt       = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_good_image();
        test_bad_csum();
        test_len_error(8'h24, "len_too_big");
        test_len_error(8'h06, "len_unaligned");
        test_zero_len();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
